pool_requant: RTL and testbench
===============================

# pool_requant

Downstream consumer of the partial-sum buffer's ReLU output stream. Takes one post-ReLU accumulated pixel per valid cycle, in raster order, for a feature-map row of `ROW_LEN` pixels. Performs 2x2 stride-2 max pooling using a half-row line buffer, then requantizes the pooled value to `OUT_W` unsigned bits with a programmable right shift and saturation. Output goes to the output feature-map writer.

## Interface
- `DATA_W`, 25: input pixel width; must match the partial-sum buffer data width.
- `OUT_W`, 8: output pixel width, unsigned.
- `ROW_LEN`, 62: input pixels per row; must be even and ≥ 2.
- `SHIFT_W`, 5: width of the `shift` input.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  synchronous restart of the row and column position.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_data`  in  `DATA_W`  post-ReLU pixel.
- `shift`  in  `SHIFT_W`  requantization right shift; static during a frame.
- `out_valid`  out  1  `out_data` holds a pooled pixel.
- `out_data`  out  `OUT_W`  requantized pooled pixel.
- `out_row_end`  out  1  qualifies `out_valid`; marks the last pooled pixel of an output row.

## Operation
- Counters:
  - `col` runs 0..`ROW_LEN`-1 and advances on each accepted `in_valid`, wrapping to 0.
  - `row_odd` toggles when `col` wraps.
- Input handling: `in_data` is treated as unsigned. If its MSB is set (no valid ReLU output does this), it is forced to 0.
- Even `col`: capture the pixel in the `hold` register.
- Odd `col`: `hmax = max(hold, in_data)`.
  - If `row_odd`=0: write `hmax` to `lb[col>>1]`. The line buffer has `ROW_LEN/2` entries and a combinational read. No output is produced.
  - If `row_odd`=1: `vmax_r <= max(hmax, lb[col>>1])`. Set stage-1 valid. Set stage-1 row_end when `col`=`ROW_LEN`-1.
- Stage 2 (requantize):
  - `q = vmax_r >> shift`.
  - If `q` > 2^`OUT_W`-1, saturate to 2^`OUT_W`-1.
  - If `shift` ≥ `DATA_W`, `q` = 0.
  - The result is registered into `out_data`, with `out_valid` and `out_row_end` set from stage 1.
- `frame_start`:
  - Clears `col`, `row_odd` and `hold`.
  - If `in_valid` is high in the same cycle, that pixel is taken as col 0, row 0 of the new frame.
  - Results already in stage 1 or stage 2 still emerge normally.
- Input gaps: `in_valid` may drop for any number of cycles. Counters and `hold` keep their values, and the pipeline still drains.
- There is no back-pressure. The consumer must accept one output every cycle.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_row_end`=0.
  - `col`=0, `row_odd`=0, `hold`=0, `vmax_r`=0, all stage valid flags 0.
  - `lb` is not reset.
- Latency: an odd-row, odd-`col` pixel accepted at edge t produces `out_valid` high for one cycle after edge t+2.
- Throughput: at most one output per 2 input cycles on odd rows. There are no outputs on even rows.
- Mid-operation reset: `rst_n` low clears all in-flight results. After release the next pixel is col 0, row 0.
- Output count: `out_valid` pulses exactly `ROW_LEN/2` times per input row pair.

## Configuration
- `POOL_ROUND_EN`
  - Defined: round-half-up before saturation. `q = (vmax_r + (1 << (shift-1))) >> shift` when `shift` > 0. The adder is `DATA_W`+1 bits wide, so it cannot overflow.
  - Undefined: plain truncating shift.
  - With `shift`=0 the result is the same either way.

## Test plan
- `ROW_LEN`=4, `shift`=0. Row 0 = 1,5,2,3; row 1 = 4,0,9,1. Required: `out_data` 5 then 9. `out_row_end` is 0 on the first output and 1 on the second. Each output appears 2 cycles after its triggering input.
- Saturation: pooled max 300, `shift`=0 → `out_data`=255. Same pixel with `shift`=2 → 75.
- Rounding: pooled 6, `shift`=2 → 1 without `POOL_ROUND_EN`, 2 with `POOL_ROUND_EN`. Pooled 5, `shift`=2 → 1 in both builds.
- Gaps and MSB: random `in_valid` gaps on the first vector give identical outputs. A pixel with MSB set, presented at the position of value 5, is treated as 0, so the first output becomes 4.
- `frame_start` asserted after 3 pixels of row 1: outputs already in flight drain. The next 8 pixels are treated as a fresh frame and give the expected maxima.
- Reset asserted while `out_valid` is pending: `out_valid` never rises. The first frame after release pools correctly.

Source files
------------

// File: rtl/pool_requant_if.sv
// Stream bundle between the ReLU output, the pooling/requant block and the
// output feature-map writer.
interface pool_requant_if #(
  parameter int unsigned DATA_W  = 25,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 5
);
  logic               frame_start;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [SHIFT_W-1:0] shift;
  logic               out_valid;
  logic [OUT_W-1:0]   out_data;
  logic               out_row_end;

  // Producer side: drives pixels and configuration, observes pooled output.
  modport master (
    output frame_start, in_valid, in_data, shift,
    input  out_valid, out_data, out_row_end
  );

  // Pooling block side.
  modport slave (
    input  frame_start, in_valid, in_data, shift,
    output out_valid, out_data, out_row_end
  );
endinterface

// File: rtl/pool_requant.sv
// pool_requant: 2x2 stride-2 max pooling over a raster pixel stream with a
// half-row line buffer, followed by right-shift requantization with
// saturation to OUT_W unsigned bits.
// Optional feature macro: POOL_ROUND_EN (round-half-up before saturation).
module pool_requant #(
  parameter int unsigned DATA_W  = 25,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned ROW_LEN = 62,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  pool_requant_if.slave     bus
);

  localparam int unsigned COL_W    = $clog2(ROW_LEN);
  localparam int unsigned LB_DEPTH = ROW_LEN / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int unsigned EXT_W    = DATA_W + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);
  localparam logic [EXT_W-1:0] SAT_MAX  = {{(EXT_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  // Position and pooling state
  logic [COL_W-1:0]  col_q, col_d;
  logic              row_odd_q, row_odd_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] vmax_q, vmax_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_end_q, s1_end_d;
  // Shifted value, saturated on the way into the output register
  logic [EXT_W-1:0]  s2_q, s2_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_end_q, s2_end_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_row_end_q, out_row_end_d;

  logic [DATA_W-1:0] lb_q [LB_DEPTH];

  logic [COL_W-1:0]  col_base_c;
  logic              row_base_c;
  logic [DATA_W-1:0] hold_base_c;
  logic [DATA_W-1:0] pix_c;
  logic [LB_AW-1:0]  lb_idx_c;
  logic [DATA_W-1:0] lb_rd_c;
  logic [DATA_W-1:0] hmax_c;
  logic [DATA_W-1:0] vmax_c;
  logic              lb_we_c;
  logic [EXT_W-1:0]  rnd_c;
  logic [EXT_W-1:0]  shifted_c;
  logic [OUT_W-1:0]  sat_c;

  // Effective position for this cycle: frame_start restarts at col 0, row 0
  always_comb begin
    col_base_c  = bus.frame_start ? '0   : col_q;
    row_base_c  = bus.frame_start ? 1'b0 : row_odd_q;
    hold_base_c = bus.frame_start ? '0   : hold_q;
    pix_c       = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
    lb_idx_c    = LB_AW'(col_base_c >> 1);
    lb_rd_c     = lb_q[lb_idx_c];
    hmax_c      = (pix_c > hold_base_c) ? pix_c : hold_base_c;
    vmax_c      = (lb_rd_c > hmax_c) ? lb_rd_c : hmax_c;
  end

  // Horizontal/vertical max, counters and stage-1 capture
  always_comb begin
    col_d      = col_q;
    row_odd_d  = row_odd_q;
    hold_d     = hold_q;
    vmax_d     = vmax_q;
    s1_valid_d = 1'b0;
    s1_end_d   = 1'b0;
    lb_we_c    = 1'b0;
    if (bus.frame_start) begin
      col_d     = '0;
      row_odd_d = 1'b0;
      hold_d    = '0;
    end
    if (bus.in_valid) begin
      if (!col_base_c[0]) begin
        hold_d = pix_c;
      end else if (!row_base_c) begin
        lb_we_c = 1'b1;
      end else begin
        vmax_d     = vmax_c;
        s1_valid_d = 1'b1;
        s1_end_d   = (col_base_c == LAST_COL);
      end
      if (col_base_c == LAST_COL) begin
        col_d     = '0;
        row_odd_d = ~row_base_c;
      end else begin
        col_d = col_base_c + COL_W'(1);
      end
    end
  end

  // Requantizing shift; shifts of DATA_W or more flush to zero
  always_comb begin
    rnd_c = '0;
`ifdef POOL_ROUND_EN
    if (bus.shift != '0) begin
      rnd_c = EXT_W'(1) << (bus.shift - SHIFT_W'(1));
    end
`endif
    if (32'(bus.shift) >= DATA_W) begin
      shifted_c = '0;
    end else begin
      shifted_c = ({1'b0, vmax_q} + rnd_c) >> bus.shift;
    end
    sat_c = (s2_q > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(s2_q);
  end

  // Stage-2 and output register next values
  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_end_d      = s1_end_q;
    s2_d          = s1_valid_q ? shifted_c : s2_q;
    out_valid_d   = s2_valid_q;
    out_row_end_d = s2_valid_q & s2_end_q;
    out_data_d    = s2_valid_q ? sat_c : out_data_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      row_odd_q     <= 1'b0;
      hold_q        <= '0;
      vmax_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_end_q      <= 1'b0;
      s2_q          <= '0;
      s2_valid_q    <= 1'b0;
      s2_end_q      <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_row_end_q <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_odd_q     <= row_odd_d;
      hold_q        <= hold_d;
      vmax_q        <= vmax_d;
      s1_valid_q    <= s1_valid_d;
      s1_end_q      <= s1_end_d;
      s2_q          <= s2_d;
      s2_valid_q    <= s2_valid_d;
      s2_end_q      <= s2_end_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_row_end_q <= out_row_end_d;
    end
  end

  // Even-row horizontal maxima; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (lb_we_c) begin
      lb_q[lb_idx_c] <= hmax_c;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_row_end = out_row_end_q;

endmodule

// File: tb/tb_pool_requant.sv
// Scoreboard bench for pool_requant with a 4-pixel row.
module tb_pool_requant;

  localparam int unsigned DATA_W  = 25;
  localparam int unsigned OUT_W   = 8;
  localparam int unsigned ROW_LEN = 4;
  localparam int unsigned SHIFT_W = 5;

  typedef struct {
    int     data;
    bit     row_end;
    longint acc;
  } exp_t;

  logic clk;
  logic rst_n;
  longint cyc;
  int n_tests;
  int n_fail;

  exp_t sb[$];
  int   seen_d[$];
  bit   seen_e[$];

  int m_col;
  bit m_row;
  int m_hold;
  int m_lb [ROW_LEN/2];
  int vec [8];

  pool_requant_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

  pool_requant #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .ROW_LEN(ROW_LEN),
    .SHIFT_W(SHIFT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int requant(input int v, input int sh);
    longint q;
    if (sh >= int'(DATA_W)) return 0;
    q = longint'(v);
`ifdef POOL_ROUND_EN
    if (sh > 0) q = q + (longint'(1) << (sh - 1));
`endif
    q = q >>> sh;
    if (q > 255) q = 255;
    return int'(q);
  endfunction

  // Reference model of position, hold and line buffer
  task automatic model(input int d, input bit fs);
    int px;
    int hm;
    int vm;
    exp_t e;
    if (fs) begin
      m_col  = 0;
      m_row  = 1'b0;
      m_hold = 0;
    end
    px = (d >= (1 << (DATA_W - 1))) ? 0 : d;
    if ((m_col % 2) == 0) begin
      m_hold = px;
    end else begin
      hm = (px > m_hold) ? px : m_hold;
      if (!m_row) begin
        m_lb[m_col/2] = hm;
      end else begin
        vm = (m_lb[m_col/2] > hm) ? m_lb[m_col/2] : hm;
        e.data    = requant(vm, int'(bus.shift));
        e.row_end = (m_col == int'(ROW_LEN) - 1);
        e.acc     = cyc + 1;
        sb.push_back(e);
      end
    end
    if (m_col == int'(ROW_LEN) - 1) begin
      m_col = 0;
      m_row = ~m_row;
    end else begin
      m_col++;
    end
  endtask

  task automatic drive(input int d, input bit fs);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_data     = DATA_W'(d);
    bus.frame_start = fs;
    model(d, fs);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid    = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
    idle(3);
    chk("drain", longint'(sb.size()), 0);
  endtask

  task automatic run_vec(input int v[8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      drive(v[i], 1'b0);
      if (gaps) idle(int'($urandom_range(0, 3)));
    end
    drain();
  endtask

  task automatic clear_seen();
    seen_d.delete();
    seen_e.delete();
  endtask

  task automatic chk_two(input string tag, input int d0, input int d1);
    chk({tag, "_count"}, longint'(seen_d.size()), 2);
    if (seen_d.size() == 2) begin
      chk({tag, "_d0"}, seen_d[0], d0);
      chk({tag, "_d1"}, seen_d[1], d1);
      chk({tag, "_e0"}, seen_e[0], 0);
      chk({tag, "_e1"}, seen_e[1], 1);
    end
  endtask

  // Output monitor: pops the scoreboard on every pooled pixel
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid === 1'b1) begin
      seen_d.push_back(int'(bus.out_data));
      seen_e.push_back(bus.out_row_end);
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", longint'(bus.out_data), e.data);
        chk("out_row_end", longint'(bus.out_row_end), e.row_end);
        chk("latency", cyc - e.acc, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    n_tests = 0;
    n_fail = 0;
    m_col = 0;
    m_row = 1'b0;
    m_hold = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.frame_start = 1'b0;
    bus.shift = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    chk("rst_out_row_end", longint'(bus.out_row_end), 0);
    rst_n = 1'b1;
    idle(2);

    // Basic 2x2 pooling
    clear_seen();
    vec = '{1, 5, 2, 3, 4, 0, 9, 1};
    run_vec(vec, 1'b0);
    chk_two("basic", 5, 9);

    // Same vector with random input gaps
    clear_seen();
    run_vec(vec, 1'b1);
    chk_two("gaps", 5, 9);

    // MSB-set pixel forced to zero
    clear_seen();
    vec = '{1, 1 << 24, 2, 3, 4, 0, 9, 1};
    run_vec(vec, 1'b0);
    chk_two("msb", 4, 9);

    // Saturation and shift
    clear_seen();
    vec = '{300, 0, 0, 0, 0, 0, 0, 0};
    run_vec(vec, 1'b0);
    chk_two("sat_sh0", 255, 0);
    clear_seen();
    bus.shift = SHIFT_W'(2);
    run_vec(vec, 1'b0);
    chk_two("sat_sh2", 75, 0);

    // Rounding
    clear_seen();
    vec = '{6, 0, 5, 0, 0, 0, 0, 0};
    run_vec(vec, 1'b0);
`ifdef POOL_ROUND_EN
    chk_two("round", 2, 1);
`else
    chk_two("round", 1, 1);
`endif

    // Shift at and beyond the data width flushes to zero
    clear_seen();
    vec = '{300, 7, 0, 1000, 0, 0, 0, 0};
    bus.shift = SHIFT_W'(DATA_W);
    run_vec(vec, 1'b0);
    chk_two("shift_wide", 0, 0);
    clear_seen();
    bus.shift = SHIFT_W'(31);
    run_vec(vec, 1'b0);
    chk_two("shift_max", 0, 0);
    clear_seen();
    bus.shift = SHIFT_W'(1);
    run_vec(vec, 1'b0);
`ifdef POOL_ROUND_EN
    chk_two("shift1", 150, 255);
`else
    chk_two("shift1", 150, 255);
`endif
    bus.shift = '0;

    // frame_start after 3 pixels of row 1
    clear_seen();
    drive(1, 1'b0); drive(5, 1'b0); drive(2, 1'b0); drive(3, 1'b0);
    drive(4, 1'b0); drive(0, 1'b0); drive(9, 1'b0);
    drive(7, 1'b1); drive(2, 1'b0); drive(8, 1'b0); drive(1, 1'b0);
    drive(3, 1'b0); drive(6, 1'b0); drive(0, 1'b0); drive(4, 1'b0);
    drain();
    chk("fs_count", longint'(seen_d.size()), 3);
    if (seen_d.size() == 3) begin
      chk("fs_d0", seen_d[0], 5);
      chk("fs_d1", seen_d[1], 7);
      chk("fs_d2", seen_d[2], 8);
      chk("fs_e2", seen_e[2], 1);
    end

    // Reset while a result is in flight
    clear_seen();
    drive(1, 1'b0); drive(5, 1'b0); drive(2, 1'b0); drive(3, 1'b0);
    drive(4, 1'b0); drive(0, 1'b0);
    idle(4);
    drive(9, 1'b0); drive(1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    m_col = 0;
    m_row = 1'b0;
    m_hold = 0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_hold_valid", longint'(bus.out_valid), 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rel_valid", longint'(bus.out_valid), 0);
    end
    chk("rst_seen", longint'(seen_d.size()), 1);
    clear_seen();
    vec = '{1, 5, 2, 3, 4, 0, 9, 1};
    run_vec(vec, 1'b0);
    chk_two("post_rst", 5, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
